// File: rtl/mini68k_movem_pkg.sv
// Shared definitions for the MOVEM sequencer.
// Holds the FSM states, the size codes and the mask-bit-to-register mapping.
package mini68k_movem_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SEL,
        S_BUS,
        S_WB,
        S_DONE
    } state_t;

    localparam logic SIZE_WORD = 1'b0;
    localparam logic SIZE_LONG = 1'b1;

    localparam logic [3:0] REG_MIRROR = 4'hF;

    // -(An) lists are bit-reversed: bit 0 names A7, bit 15 names D0.
    function automatic logic [3:0] reg_of(input logic predec,
                                          input logic [3:0] bit_idx);
        return predec ? (REG_MIRROR - bit_idx) : bit_idx;
    endfunction

    function automatic logic [31:0] step_of(input logic size);
        return (size == SIZE_LONG) ? 32'd4 : 32'd2;
    endfunction

endpackage

// File: rtl/mini68k_movem_pick.sv
// Lowest-set-bit priority encoder over the remaining register list.
// valid is low when no bit is set; idx is then 0.
module mini68k_movem_pick
    import mini68k_movem_pkg::*;
(
    input  logic [15:0] mask,
    output logic        valid,
    output logic [3:0]  idx
);

    always_comb begin
        valid = 1'b0;
        idx   = 4'd0;
        for (int i = 15; i >= 0; i--) begin
            if (mask[i]) begin
                valid = 1'b1;
                idx   = i[3:0];
            end
        end
    end

endmodule

// File: rtl/mini68k_movem_engine.sv
// MOVEM sequencer: one register per bus transfer between the
// register file and memory, with -(An) address update.
module mini68k_movem_engine
    import mini68k_movem_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        dir,
    input  logic        size,
    input  logic        predec,
    input  logic [15:0] mask,
    input  logic [31:0] base_addr,
    output logic        busy,
    output logic        done,
    output logic [31:0] final_addr,
    output logic [2:0]  rf_sel,
    output logic        rf_is_addr,
    output logic        rf_we,
    output logic [31:0] rf_wdata,
    input  logic [31:0] rf_rdata,
    output logic        bus_req,
    output logic        bus_we,
    output logic        bus_size,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata
);

    state_t      state, state_nx;
    logic        l_dir, l_size, l_predec;
    logic [15:0] l_mask;
    logic [31:0] cur_addr;
    logic [31:0] wdata_q;
    logic [31:0] rdata_q;
    logic [31:0] final_q;
    logic [3:0]  cur_bit;
    logic        pick_valid;
    logic [3:0]  pick_idx;
    logic [31:0] step;
    logic [15:0] mask_left;
    logic [3:0]  reg_idx;

    mini68k_movem_pick u_pick (
        .mask  (l_mask),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    assign step      = step_of(l_size);
    assign mask_left = l_mask & ~(16'h0001 << cur_bit);

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            l_dir    <= 1'b0;
            l_size   <= 1'b0;
            l_predec <= 1'b0;
            l_mask   <= 16'h0000;
            cur_addr <= 32'h0;
            wdata_q  <= 32'h0;
            rdata_q  <= 32'h0;
            final_q  <= 32'h0;
            cur_bit  <= 4'd0;
        end else begin
            state <= state_nx;
            unique case (state)
                S_IDLE: begin
                    if (start) begin
                        l_dir    <= dir & ~predec;
                        l_size   <= size;
                        l_predec <= predec;
                        l_mask   <= mask;
                        cur_addr <= base_addr;
                    end
                end
                S_SEL: begin
                    cur_bit <= pick_idx;
                    if (!l_dir) begin
                        wdata_q <= (l_size == SIZE_LONG) ? rf_rdata
                                 : {16'h0000, rf_rdata[15:0]};
                    end
                    if (l_predec) cur_addr <= cur_addr - step;
                end
                S_BUS: begin
                    if (bus_ack) begin
                        l_mask  <= mask_left;
                        rdata_q <= bus_rdata;
                        if (!l_predec) cur_addr <= cur_addr + step;
                    end
                end
                S_DONE: final_q <= cur_addr;
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            S_IDLE: begin
                if (start) state_nx = (mask == 16'h0000) ? S_DONE : S_SEL;
            end
            S_SEL: state_nx = pick_valid ? S_BUS : S_DONE;
            S_BUS: begin
                if (bus_ack) begin
                    if (l_dir)                    state_nx = S_WB;
                    else if (mask_left != 16'h0)  state_nx = S_SEL;
                    else                          state_nx = S_DONE;
                end
            end
            S_WB:   state_nx = (l_mask != 16'h0) ? S_SEL : S_DONE;
            S_DONE: state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        busy       = (state != S_IDLE);
        done       = (state == S_DONE);
        final_addr = (state == S_DONE) ? cur_addr : final_q;
        bus_req    = (state == S_BUS);
        bus_we     = (state == S_BUS) & ~l_dir;
        bus_size   = l_size;
        bus_addr   = (state == S_BUS) ? cur_addr : 32'h0;
        bus_wdata  = ((state == S_BUS) && !l_dir) ? wdata_q : 32'h0;
        rf_we      = (state == S_WB);
        rf_wdata   = 32'h0;
        if (state == S_WB) begin
            rf_wdata = (l_size == SIZE_LONG) ? rdata_q
                     : {{16{rdata_q[15]}}, rdata_q[15:0]};
        end
        reg_idx    = reg_of(l_predec, (state == S_SEL) ? pick_idx : cur_bit);
        rf_sel     = 3'd0;
        rf_is_addr = 1'b0;
        if (state == S_SEL || state == S_BUS || state == S_WB) begin
            rf_sel     = reg_idx[2:0];
            rf_is_addr = reg_idx[3];
        end
    end

endmodule

// File: tb/tb_mini68k_movem_engine.sv
// Randomized self-checking bench for mini68k_movem_engine.
// Expected transfers come from a list model of the MOVEM rules.
module tb_mini68k_movem_engine;

    logic        clk = 1'b0;
    logic        rst;
    logic        start, dir, size, predec;
    logic [15:0] mask;
    logic [31:0] base_addr;
    logic        busy, done;
    logic [31:0] final_addr;
    logic [2:0]  rf_sel;
    logic        rf_is_addr, rf_we;
    logic [31:0] rf_wdata, rf_rdata;
    logic        bus_req, bus_we, bus_size;
    logic [31:0] bus_addr, bus_wdata;
    logic        bus_ack;
    logic [31:0] bus_rdata;

    logic [31:0] rf [16];
    bit          use_forced;
    logic [31:0] forced_rdata;
    int          errs = 0;
    int          checks = 0;

    always #5 clk = ~clk;

    assign rf_rdata = rf[{rf_is_addr, rf_sel}];

    mini68k_movem_engine dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .dir        (dir),
        .size       (size),
        .predec     (predec),
        .mask       (mask),
        .base_addr  (base_addr),
        .busy       (busy),
        .done       (done),
        .final_addr (final_addr),
        .rf_sel     (rf_sel),
        .rf_is_addr (rf_is_addr),
        .rf_we      (rf_we),
        .rf_wdata   (rf_wdata),
        .rf_rdata   (rf_rdata),
        .bus_req    (bus_req),
        .bus_we     (bus_we),
        .bus_size   (bus_size),
        .bus_addr   (bus_addr),
        .bus_wdata  (bus_wdata),
        .bus_ack    (bus_ack),
        .bus_rdata  (bus_rdata)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic run_op(input logic d, input logic s, input logic p,
                          input logic [15:0] m, input logic [31:0] base,
                          input int maxd, input bit restart);
        int          q_reg[$];
        logic [31:0] q_addr[$];
        logic [31:0] a, st, msk, ldat, h_addr, h_wd;
        int          exp_cyc, dly, k, curreg;
        bit          inx, got_done, ld;
        ld  = d & ~p;
        st  = s ? 32'd4 : 32'd2;
        msk = s ? 32'hFFFF_FFFF : 32'h0000_FFFF;
        a   = base;
        for (int i = 0; i < 16; i++) begin
            if (m[i]) begin
                if (p) a = a - st;
                q_addr.push_back(a);
                q_reg.push_back(p ? 15 - i : i);
                if (!p) a = a + st;
            end
        end
        exp_cyc  = 1;
        k        = 0;
        dly      = 0;
        curreg   = 0;
        inx      = 0;
        got_done = 0;
        ldat     = 32'h0;
        h_addr   = 32'h0;
        h_wd     = 32'h0;
        @(negedge clk);
        dir = d; size = s; predec = p; mask = m; base_addr = base;
        start = 1'b1;
        for (int cyc = 1; cyc <= 2000; cyc++) begin
            @(negedge clk);
            start   = restart && (cyc == 2);
            mask    = $urandom;
            base_addr = $urandom;
            bus_ack = 1'b0;
            if (cyc == 1) chk("busy_first", {31'h0, busy}, 32'h1);
            if (bus_req && rf_we) chk("exclusive", 32'h1, 32'h0);
            if (rf_we && !ld) chk("we_on_store", 32'h1, 32'h0);
            if (bus_req) begin
                if (!inx) begin
                    inx = 1;
                    dly = $urandom_range(0, maxd);
                    if (k >= q_reg.size()) begin
                        chk("extra_xfer", 32'h1, 32'h0);
                        curreg = 0;
                    end else begin
                        curreg = q_reg[k];
                        chk("bus_addr", bus_addr, q_addr[k]);
                        chk("bus_we", {31'h0, bus_we}, {31'h0, ~ld});
                        chk("bus_size", {31'h0, bus_size}, {31'h0, s});
                        if (!ld) chk("bus_wdata", bus_wdata & msk,
                                     rf[curreg] & msk);
                    end
                    h_addr  = bus_addr;
                    h_wd    = bus_wdata;
                    exp_cyc = exp_cyc + 2 + dly + (ld ? 1 : 0);
                end else begin
                    chk("addr_stable", bus_addr, h_addr);
                    chk("wdata_stable", bus_wdata, h_wd);
                end
                if (dly == 0) begin
                    ldat      = use_forced ? forced_rdata : $urandom;
                    bus_ack   = 1'b1;
                    bus_rdata = ldat;
                    inx       = 0;
                    k++;
                end else begin
                    dly--;
                end
            end
            if (rf_we) begin
                chk("rf_reg", {28'h0, rf_is_addr, rf_sel}, curreg);
                chk("rf_wdata", rf_wdata,
                    s ? ldat : {{16{ldat[15]}}, ldat[15:0]});
                rf[curreg] = rf_wdata;
            end
            if (done) begin
                chk("final_addr", final_addr, a);
                chk("xfer_count", k, q_reg.size());
                chk("latency", cyc, exp_cyc);
                got_done = 1;
                break;
            end
        end
        if (!got_done) chk("timeout", 32'h1, 32'h0);
        @(negedge clk);
        bus_ack = 1'b0;
        chk("idle_after", {31'h0, busy}, 32'h0);
        chk("final_held", final_addr, a);
    endtask

    initial begin
        logic [31:0] h_addr, h_wd;
        bit          seen;
        rst = 1'b1; start = 0; dir = 0; size = 0; predec = 0;
        mask = 0; base_addr = 0; bus_ack = 0; bus_rdata = 0;
        use_forced = 0; forced_rdata = 0;
        for (int i = 0; i < 16; i++) rf[i] = $urandom;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("rst_busy", {31'h0, busy}, 32'h0);
        chk("rst_done", {31'h0, done}, 32'h0);
        chk("rst_req", {31'h0, bus_req}, 32'h0);
        chk("rst_we", {31'h0, rf_we}, 32'h0);
        chk("rst_final", final_addr, 32'h0);

        rf[0] = 32'h1111_1111; rf[1] = 32'h2222_2222;
        run_op(0, 1, 0, 16'h0003, 32'h0000_1000, 0, 0);

        rf[15] = 32'hAAAA_1234; rf[0] = 32'h0000_BEEF;
        run_op(0, 0, 1, 16'h8001, 32'h0000_2000, 0, 0);

        use_forced = 1; forced_rdata = 32'h0000_8000;
        run_op(1, 0, 0, 16'h0100, 32'h0000_3000, 0, 0);
        use_forced = 0;
        chk("a0_loaded", rf[8], 32'hFFFF_8000);

        run_op(0, 1, 0, 16'h0000, 32'h1234_5678, 0, 0);

        @(negedge clk);
        dir = 0; size = 1; predec = 0; mask = 16'h0003;
        base_addr = 32'h0000_5000; start = 1;
        @(negedge clk);
        start = 0;
        seen = 0;
        h_addr = 0;
        h_wd = 0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            if (bus_req) begin
                seen = 1;
                h_addr = bus_addr;
                h_wd = bus_wdata;
            end
        end
        chk("rst_case_req", {31'h0, seen}, 32'h1);
        chk("rst_case_addr", h_addr, 32'h0000_5000);
        chk("rst_case_wd", h_wd, rf[0]);
        repeat (2) begin
            @(negedge clk);
            chk("hold_addr", bus_addr, h_addr);
            chk("hold_wd", bus_wdata, h_wd);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mid_rst_req", {31'h0, bus_req}, 32'h0);
        chk("mid_rst_busy", {31'h0, busy}, 32'h0);
        bus_ack = 1'b1;
        @(negedge clk);
        bus_ack = 1'b0;
        chk("late_ack_busy", {31'h0, busy}, 32'h0);
        chk("late_ack_we", {31'h0, rf_we}, 32'h0);
        run_op(0, 1, 0, 16'h0003, 32'h0000_5000, 2, 0);

        run_op(0, 1, 0, 16'h0003, 32'hFFFF_FFFC, 1, 1);

        for (int t = 0; t < 24; t++) begin
            logic [15:0] rm;
            rm = $urandom;
            if (t % 8 == 7) rm = 16'h0;
            run_op($urandom_range(0, 1), $urandom_range(0, 1),
                   $urandom_range(0, 1), rm, $urandom, 3,
                   (rm != 0) && ($urandom_range(0, 1) == 1));
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
